wb_arb2: RTL



---
 rtl/wb_arb_pkg.sv | 14 +
 rtl/wb_arb_wdt.sv | 31 +++
 rtl/wb_arb2.sv | 123 ++++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: grant state encoding and default widths.
// The optional watchdog is enabled by WB_ARB_TIMEOUT_EN (see wb_arb2 / wb_arb_wdt).
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } arb_state_t;

  localparam int DEFAULT_AW = 24;
  localparam int DEFAULT_DW = 8;

endpackage

// File: rtl/wb_arb_wdt.sv
// Ack watchdog for wb_arb2: counts unanswered strobe cycles of the granted master.
// Only exists when WB_ARB_TIMEOUT_EN is defined.
`ifdef WB_ARB_TIMEOUT_EN
module wb_arb_wdt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic stb,
  input  logic ack,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // Clearing throughout IDLE also covers the clear on grant and on release.
  always_ff @(posedge clk) begin
    if (rst || ack || !active) begin
      count <= '0;
    end else if (stb) begin
      count <= count + 1'b1;
    end
  end

  assign expired = active && (count == CW'(TIMEOUT));

endmodule
`endif

// File: rtl/wb_arb2.sv
// Two-master round-robin Wishbone arbiter; grant is held for a master's whole cyc burst.
// Define WB_ARB_TIMEOUT_EN to add the ack watchdog that aborts a stalled burst with err.
module wb_arb2
  import wb_arb_pkg::*;
#(
  parameter int AW      = DEFAULT_AW,
  parameter int DW      = DEFAULT_DW,
  parameter int TIMEOUT = 255
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst,
  input  logic          i_m0_cyc,
  input  logic          i_m0_stb,
  input  logic          i_m0_we,
  input  logic [AW-1:0] i_m0_addr,
  input  logic [DW-1:0] i_m0_dat,
  output logic [DW-1:0] o_m0_dat,
  output logic          o_m0_ack,
  output logic          o_m0_err,
  input  logic          i_m1_cyc,
  input  logic          i_m1_stb,
  input  logic          i_m1_we,
  input  logic [AW-1:0] i_m1_addr,
  input  logic [DW-1:0] i_m1_dat,
  output logic [DW-1:0] o_m1_dat,
  output logic          o_m1_ack,
  output logic          o_m1_err,
  output logic          o_s_cyc,
  output logic          o_s_stb,
  output logic          o_s_we,
  output logic [AW-1:0] o_s_addr,
  output logic [DW-1:0] o_s_dat,
  input  logic [DW-1:0] i_s_dat,
  input  logic          i_s_ack
);

  arb_state_t    state;
  logic          last;
  logic          expired;
  logic          gnt_cyc;
  logic          gnt_stb;
  logic          gnt_we;
  logic [AW-1:0] gnt_addr;
  logic [DW-1:0] gnt_dat;

  // last = 1 means master 1 was served most recently, so master 0 wins a tie.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (i_m0_cyc && (!i_m1_cyc || last)) begin
            state <= G0;
            last  <= 1'b0;
          end else if (i_m1_cyc) begin
            state <= G1;
            last  <= 1'b1;
          end
        end
        G0: if (!i_m0_cyc || expired) state <= IDLE;
        G1: if (!i_m1_cyc || expired) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    gnt_cyc  = 1'b0;
    gnt_stb  = 1'b0;
    gnt_we   = 1'b0;
    gnt_addr = '0;
    gnt_dat  = '0;
    case (state)
      G0: begin
        gnt_cyc  = i_m0_cyc;
        gnt_stb  = i_m0_stb;
        gnt_we   = i_m0_we;
        gnt_addr = i_m0_addr;
        gnt_dat  = i_m0_dat;
      end
      G1: begin
        gnt_cyc  = i_m1_cyc;
        gnt_stb  = i_m1_stb;
        gnt_we   = i_m1_we;
        gnt_addr = i_m1_addr;
        gnt_dat  = i_m1_dat;
      end
      default: ;
    endcase
  end

`ifdef WB_ARB_TIMEOUT_EN
  wb_arb_wdt #(
    .TIMEOUT(TIMEOUT)
  ) u_wdt (
    .clk    (i_wb_clk),
    .rst    (i_wb_rst),
    .active (state != IDLE),
    .stb    (gnt_stb),
    .ack    (i_s_ack),
    .expired(expired)
  );
`else
  // Without the watchdog a burst never expires.
  assign expired = (TIMEOUT < 0);
`endif

  assign o_s_cyc  = gnt_cyc & ~expired;
  assign o_s_stb  = gnt_stb & ~expired;
  assign o_s_we   = gnt_we;
  assign o_s_addr = gnt_addr;
  assign o_s_dat  = gnt_dat;

  assign o_m0_dat = i_s_dat;
  assign o_m1_dat = i_s_dat;
  assign o_m0_ack = i_s_ack & (state == G0);
  assign o_m1_ack = i_s_ack & (state == G1);
  assign o_m0_err = expired & (state == G0);
  assign o_m1_err = expired & (state == G1);

endmodule
